// File: rtl/global_types.sv
// global_types: shared typedefs, opcode/funct encodings, ALU ops and address map for mips_soc.
package global_types;
    typedef logic [31:0] logic32;
    typedef logic [15:0] logic16;
    typedef logic [3:0]  logic4;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_MUL   = 6'h1C;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_MUL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_MUL} alu_op_t;

    localparam logic32 ADDR_GPIO_IN  = 32'h0000_0800;
    localparam logic32 ADDR_GPIO_OUT = 32'h0000_0900;
endpackage

// File: rtl/soc_alu.sv
// soc_alu: combinational ALU for mips_soc (add, sub, and, or, signed slt, low-32 mul).
module soc_alu
    import global_types::*;
(
    input  logic32  a,
    input  logic32  b,
    input  alu_op_t op,
    output logic32  y
);
    always_comb begin
        y = op == ALU_SUB ? a - b :
            op == ALU_AND ? a & b :
            op == ALU_OR  ? a | b :
            op == ALU_SLT ? {31'b0, $signed(a) < $signed(b)} :
            op == ALU_MUL ? a * b :
                            a + b;
    end
endmodule

// File: rtl/mips_soc.sv
// mips_soc: single-cycle MIPS subset running a factorial ROM program with 64-word RAM and GPIO.
// Defining SOC_TRACE_EN adds a simulation-only trace of GPIO output register writes.
module mips_soc
    import global_types::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [5:0]  gpio_in1,
    output logic32      pc,
    output logic32      instruction,
    output logic32      alu_out,
    output logic32      dmem_wd,
    output logic        dmem_we,
    output logic16      gpio_out
);
    logic32  rf [0:31];
    logic32  ram [0:63];
    logic32  gpio_reg;
    logic [5:0] op, funct;
    logic [4:0] rs, rt, rd, wa;
    logic32  simm, zimm, rs_val, rt_val, alu_b, load_data, wb_data, pc4, pc_next;
    logic    is_r, r_ok, is_mul, we;
    alu_op_t alu_op;

    always_comb begin
        case (pc[7:2])
            6'd0:    instruction = 32'h8C08_0800;
            6'd1:    instruction = 32'h3108_000F;
            6'd2:    instruction = 32'h2009_0001;
            6'd3:    instruction = 32'h1100_0003;
            6'd4:    instruction = 32'h7128_4802;
            6'd5:    instruction = 32'h2108_FFFF;
            6'd6:    instruction = 32'h0800_0003;
            6'd7:    instruction = 32'hAC09_0900;
            6'd8:    instruction = 32'h0800_0000;
            default: instruction = 32'h0000_0000;
        endcase
    end

    assign op     = instruction[31:26];
    assign rs     = instruction[25:21];
    assign rt     = instruction[20:16];
    assign rd     = instruction[15:11];
    assign funct  = instruction[5:0];
    assign simm   = {{16{instruction[15]}}, instruction[15:0]};
    assign zimm   = {16'b0, instruction[15:0]};
    assign rs_val = rs == 5'd0 ? 32'b0 : rf[rs];
    assign rt_val = rt == 5'd0 ? 32'b0 : rf[rt];

    always_comb begin
        is_r   = op == OP_RTYPE;
        is_mul = op == OP_MUL && funct == FN_MUL;
        r_ok   = is_r && (funct == FN_ADD || funct == FN_SUB || funct == FN_AND ||
                          funct == FN_OR || funct == FN_SLT);
        alu_op = is_mul                                 ? ALU_MUL :
                 op == OP_ANDI                          ? ALU_AND :
                 op == OP_BEQ || op == OP_BNE           ? ALU_SUB :
                 is_r && funct == FN_SUB                ? ALU_SUB :
                 is_r && funct == FN_AND                ? ALU_AND :
                 is_r && funct == FN_OR                 ? ALU_OR  :
                 is_r && funct == FN_SLT                ? ALU_SLT :
                                                          ALU_ADD;
        alu_b  = op == OP_ANDI                                            ? zimm :
                 op == OP_ADDI || op == OP_LW || op == OP_SW              ? simm :
                                                                            rt_val;
        we     = r_ok || is_mul || op == OP_ADDI || op == OP_ANDI || op == OP_LW;
        wa     = r_ok || is_mul ? rd : rt;
    end

    soc_alu u_alu (.a(rs_val), .b(alu_b), .op(alu_op), .y(alu_out));

    // Byte addresses below 0x100 hit the 64-word RAM; everything else is memory-mapped or void
    assign load_data = alu_out[31:8] == 24'b0     ? ram[alu_out[7:2]] :
                       alu_out == ADDR_GPIO_IN    ? {26'b0, gpio_in1} : 32'b0;
    assign wb_data   = op == OP_LW ? load_data : alu_out;
    assign dmem_wd   = rt_val;
    assign dmem_we   = op == OP_SW;

    assign pc4     = pc + 32'd4;
    assign pc_next = op == OP_J                              ? {pc4[31:28], instruction[25:0], 2'b00} :
                     (op == OP_BEQ && alu_out == 32'b0) ||
                     (op == OP_BNE && alu_out != 32'b0)      ? pc4 + {simm[29:0], 2'b00} :
                                                               pc4;

    assign gpio_out = gpio_in1[5] ? 16'h0000 : gpio_in1[4] ? gpio_reg[31:16] : gpio_reg[15:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc       <= 32'b0;
            gpio_reg <= 32'b0;
            for (int i = 0; i < 32; i++) rf[i] <= 32'b0;
        end else begin
            pc <= pc_next;
            if (we && wa != 5'd0) rf[wa] <= wb_data;
            if (dmem_we && alu_out == ADDR_GPIO_OUT) gpio_reg <= dmem_wd;
        end
    end

    always_ff @(posedge clock) begin
        if (dmem_we && alu_out[31:8] == 24'b0) ram[alu_out[7:2]] <= dmem_wd;
    end

`ifdef SOC_TRACE_EN
    always_ff @(posedge clock) begin
        if (reset && dmem_we && alu_out == ADDR_GPIO_OUT)
            $display("[%0t] gpio write pc=%h value=%h", $time, pc, dmem_wd);
    end
`endif
endmodule

// File: tb/tb_mips_soc.sv
// tb_mips_soc: scoreboard bench for mips_soc factorial program, GPIO select and reset behaviour.
module tb_mips_soc;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  gpio_in1 = 6'd0;
    logic [31:0] pc, instruction, alu_out, dmem_wd;
    logic        dmem_we;
    logic [15:0] gpio_out;
    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_q[$];

    mips_soc dut (
        .clock(clock), .reset(reset), .gpio_in1(gpio_in1), .pc(pc),
        .instruction(instruction), .alu_out(alu_out), .dmem_wd(dmem_wd),
        .dmem_we(dmem_we), .gpio_out(gpio_out)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (reset && dmem_we) begin
            total++;
            if (pc !== 32'h1C) begin
                bad++;
                $display("FAIL dmem_we_pc: pc=%h required 0000001c", pc);
            end
        end
    end

    function automatic logic [31:0] fact(input int n);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 2; i <= n; i++) r = r * i;
        return r;
    endfunction

    task automatic run_n(input int n);
        logic [31:0] exp;
        int k;
        gpio_in1 = {2'b00, n[3:0]};
        exp_q.push_back(fact(n));
        k = 0;
        while (pc == 32'd0 && k < 800) begin @(negedge clock); k++; end
        while (pc != 32'd0 && k < 800) begin @(negedge clock); k++; end
        while (!dmem_we && k < 800) begin @(negedge clock); k++; end
        exp = exp_q.pop_front();
        total++;
        if (k >= 800) begin
            bad++;
            $display("FAIL store_timeout n=%0d: no sw within %0d cycles", n, k);
            return;
        end
        if (dmem_wd !== exp || alu_out !== 32'h900) begin
            bad++;
            $display("FAIL store n=%0d: data=%h addr=%h required %h/00000900", n, dmem_wd, alu_out, exp);
        end
        while (instruction != 32'h0800_0000 && k < 800) begin @(negedge clock); k++; end
        repeat (3) @(negedge clock);
        total++;
        if (gpio_out !== exp[15:0]) begin
            bad++;
            $display("FAIL gpio_low n=%0d: got %h required %h", n, gpio_out, exp[15:0]);
        end
        gpio_in1[5:4] = 2'b01;
        #1;
        total++;
        if (gpio_out !== exp[31:16]) begin
            bad++;
            $display("FAIL gpio_high n=%0d: got %h required %h", n, gpio_out, exp[31:16]);
        end
        gpio_in1[5:4] = 2'b00;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        gpio_in1 = 6'd0;
        #2;
        total += 4;
        if (pc !== 32'd0) begin bad++; $display("FAIL reset_pc: got %h required 00000000", pc); end
        if (instruction !== 32'h8C08_0800) begin bad++; $display("FAIL reset_instr: got %h required 8c080800", instruction); end
        if (gpio_out !== 16'h0000) begin bad++; $display("FAIL reset_gpio: got %h required 0000", gpio_out); end
        if (alu_out !== 32'h800) begin bad++; $display("FAIL reset_alu: got %h required 00000800", alu_out); end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        total++;
        if (pc !== 32'd4) begin bad++; $display("FAIL first_step_pc: got %h required 00000004", pc); end
    endtask

    task automatic test_n_zero;
        run_n(0);
    endtask

    task automatic test_n_five;
        run_n(5);
    endtask

    task automatic test_large;
        run_n(10);
        run_n(11);
    endtask

    task automatic test_sweep;
        for (int n = 0; n <= 11; n++) run_n(n);
    endtask

    task automatic test_sel_off;
        gpio_in1 = 6'b10_0101;
        #1;
        total++;
        if (gpio_out !== 16'h0000) begin bad++; $display("FAIL sel_10: got %h required 0000", gpio_out); end
        gpio_in1 = 6'b11_0101;
        #1;
        total++;
        if (gpio_out !== 16'h0000) begin bad++; $display("FAIL sel_11: got %h required 0000", gpio_out); end
        gpio_in1 = 6'b00_0101;
        #1;
        total++;
        if (gpio_out !== 16'h0078) begin bad++; $display("FAIL sel_00_restore: got %h required 0078", gpio_out); end
    endtask

    task automatic test_reset_mid;
        repeat (7) @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        total += 3;
        if (pc !== 32'd0) begin bad++; $display("FAIL mid_reset_pc: got %h required 00000000", pc); end
        if (gpio_out !== 16'h0000) begin bad++; $display("FAIL mid_reset_gpio: got %h required 0000", gpio_out); end
        if (instruction !== 32'h8C08_0800) begin bad++; $display("FAIL mid_reset_instr: got %h required 8c080800", instruction); end
        @(negedge clock);
        reset = 1'b1;
        run_n(3);
    endtask

    initial begin
        test_reset;
        test_n_zero;
        test_n_five;
        test_sel_off;
        test_large;
        test_sweep;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
